// File: rtl/multiword_add_seq.sv
// Multi-precision add/subtract sequencer: one shared N-bit adder walked over WORDS words, LSW first.
// Define SIGNED_OVF_EN to add the registered signed-overflow output ovf.

module nbitfull_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
endmodule

module multiword_add_seq #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               sub,
    input  logic [WORDS*N-1:0] a,
    input  logic [WORDS*N-1:0] b,
    input  logic               cin,
    output logic               busy,
    output logic               done,
    output logic [WORDS*N-1:0] sum,
`ifdef SIGNED_OVF_EN
    output logic               cout,
    output logic               ovf
`else
    output logic               cout
`endif
);
    localparam int W  = WORDS * N;
    localparam int KW = $clog2(WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k;
    logic          carry;
    logic [W-1:0]  opa_r, opb_r;
    logic [N-1:0]  wa, wb, ws;
    logic          wc;
    logic          accept, last;

    assign accept = (state_q == ST_IDLE) && start;
    assign last   = (k == KW'(WORDS - 1));
    assign wa     = opa_r[k*N +: N];
    assign wb     = opb_r[k*N +: N];

    nbitfull_adder #(.N(N)) u_adder (
        .a    (wa),
        .b    (wb),
        .cin  (carry),
        .sum  (ws),
        .cout (wc)
    );

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last)  state_d = ST_DONE;
            ST_DONE:            state_d = ST_IDLE;
            default:            state_d = ST_IDLE;
        endcase
    end

    // NOTE: operand registers are pure datapath loaded on accept, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            opa_r <= a;
            opb_r <= sub ? ~b : b;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            k       <= '0;
            carry   <= 1'b0;
`ifdef SIGNED_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            // busy/done are registered images of the next state, so they align with it.
            busy    <= (state_d != ST_IDLE);
            done    <= (state_d == ST_DONE);
            if (accept) begin
                k     <= '0;
                carry <= sub ? 1'b1 : cin;
            end else if (state_q == ST_RUN) begin
                sum[k*N +: N] <= ws;
                carry         <= wc;
                k             <= k + KW'(1);
                if (last) begin
                    cout <= wc;
`ifdef SIGNED_OVF_EN
                    // Carry into the MSB is recovered from the MSB sum bit and its operands.
                    ovf  <= (wa[N-1] ^ wb[N-1] ^ ws[N-1]) ^ wc;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq (N=8, WORDS=4): directed, random, busy-ignore,
// mid-run reset and back-to-back scenarios against a plain-arithmetic reference model.

module tb_multiword_add_seq;
    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int vectors = 0;
    int miscompares = 0;

`ifdef SIGNED_OVF_EN
    logic ovf;
    multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );
`else
    multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );
`endif

    always #5 clk = ~clk;

    // Reference: full-width two's-complement arithmetic; returns {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mcin, input logic msub);
        logic [W-1:0] bb;
        logic [W:0]   r;
        logic         c, v;
        bb = msub ? ~mb : mb;
        c  = msub ? 1'b1 : mcin;
        r  = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, c};
        v  = (ma[W-1] == bb[W-1]) && (r[W-1] != ma[W-1]);
        return {v, r};
    endfunction

    task automatic check_outputs(input string name, input logic [W-1:0] es, input logic ec,
                                 input logic ev);
        vectors++;
        if (sum !== es) begin
            miscompares++;
            $display("FAIL %s sum: got %h want %h", name, sum, es);
        end
        vectors++;
        if (cout !== ec) begin
            miscompares++;
            $display("FAIL %s cout: got %b want %b", name, cout, ec);
        end
`ifdef SIGNED_OVF_EN
        vectors++;
        if (ovf !== ev) begin
            miscompares++;
            $display("FAIL %s ovf: got %b want %b", name, ovf, ev);
        end
`else
        if (ev === 1'bx) $display("note: %s unexpected X in expected ovf", name);
`endif
    endtask

    // Starts one op from an IDLE negedge, scrambles inputs after T0, checks latency,
    // result and the one-cycle done pulse. Returns at a negedge in IDLE.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                          input logic tsub, input string name);
        logic [W+1:0] exp;
        int edges;
        exp = model(ta, tb, tcin, tsub);
        a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy after accept: got %b want 1", name, busy);
        end
        edges = 0;
        while (!done && edges < WORDS + 6) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        vectors++;
        if (!done || edges != WORDS) begin
            miscompares++;
            $display("FAIL %s latency: done=%b after %0d edges, want done=1 after %0d",
                     name, done, edges, WORDS);
        end
        check_outputs(name, exp[W-1:0], exp[W], exp[W+1]);
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after done: done=%b busy=%b want 0 0", name, done, busy);
        end
        vectors++;
        if (sum !== exp[W-1:0]) begin
            miscompares++;
            $display("FAIL %s sum hold: got %h want %h", name, sum, exp[W-1:0]);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
                miscompares++;
                $display("FAIL reset idle cycle %0d: busy=%b done=%b sum=%h cout=%b want 0 0 0 0",
                         i, busy, done, sum, cout);
            end
        end
`ifdef SIGNED_OVF_EN
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset ovf: got %b want 0", ovf);
        end
`endif
    endtask

    task automatic test_directed();
        run_op(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "add_ripple");
        check_outputs("add_ripple_const", 32'h0100_0000, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, "add_wrap");
        check_outputs("add_wrap_const", 32'h0000_0000, 1'b1, 1'b0);
        run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, "sub_borrow");
        check_outputs("sub_borrow_const", 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, "sub_ovf");
        check_outputs("sub_ovf_const", 32'h7FFF_FFFF, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        logic [W-1:0] corner [4];
        logic [W-1:0] ra, rb;
        corner[0] = '0; corner[1] = '1; corner[2] = 32'h8000_0000; corner[3] = 32'h7FFF_FFFF;
        for (int i = 0; i < 60; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            run_op(ra, rb, 1'($urandom), 1'($urandom), "random");
        end
    endtask

    task automatic test_busy_ignore_and_reset();
        logic [W+1:0] exp;
        int edges;
        exp = model(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0);
        a = 32'h1234_5678; b = 32'h0F0F_0F0F; cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 32'hDEAD_BEEF; b = 32'h1111_1111; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 2;
        while (!done && edges < WORDS + 6) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        vectors++;
        if (!done || edges != WORDS) begin
            miscompares++;
            $display("FAIL ignore latency: done=%b after %0d edges, want 1 after %0d",
                     done, edges, WORDS);
        end
        check_outputs("ignore_start", exp[W-1:0], exp[W], exp[W+1]);
        repeat (4) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL ignore not queued: busy got %b want 0", busy);
            end
        end
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun reset: busy=%b done=%b sum=%h cout=%b want 0 0 0 0",
                     busy, done, sum, cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || sum !== '0) begin
            miscompares++;
            $display("FAIL after reset idle: busy=%b sum=%h want 0 0", busy, sum);
        end
        run_op(32'h0001_00FF, 32'h0000_FF01, 1'b0, 1'b0, "post_reset");
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] e1, e2;
        int edges, first, second;
        e1 = model(32'hAAAA_5555, 32'h5555_AAAB, 1'b0, 1'b0);
        e2 = model(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b1);
        a = 32'hAAAA_5555; b = 32'h5555_AAAB; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        edges = 0; first = -1; second = -1;
        while (edges < 30 && second < 0) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done) begin
                if (first < 0) begin
                    first = edges;
                    check_outputs("b2b_first", e1[W-1:0], e1[W], e1[W+1]);
                    a = 32'h0000_0100; b = 32'h0000_0200; sub = 1'b1;
                end else begin
                    second = edges;
                    check_outputs("b2b_second", e2[W-1:0], e2[W], e2[W+1]);
                end
            end
            if (edges == WORDS + 2) start = 1'b0;
        end
        start = 1'b0;
        vectors++;
        if (first != WORDS || second != 2 * WORDS + 2) begin
            miscompares++;
            $display("FAIL b2b timing: done at edges %0d,%0d want %0d,%0d",
                     first, second, WORDS, 2 * WORDS + 2);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore_and_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
